write_buffer_ctrl: RTL and testbench
====================================

Name: write_buffer_ctrl

Overview:
Upstream write-side controller for the Sobel banked line buffers. It accepts the raster pixel stream and writes each pixel into one of three RAM banks: bank = column mod 3, address = column / 3. It issues the in-order column read requests (r_en/raddr) that drive the downstream read controller, lagged so that column x+1 is written before column x is read. It also tracks row and frame position.

Parameters:
DATA_WD, 8, pixel width
ADDR_WD, 10, column index width
RAM_WD, 8, bank address width; ceil(IMG_W/3) <= 2^RAM_WD
IMG_W, 640, pixels per row
IMG_H, 480, rows per frame
ROW_WD, 9, row counter width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
pix_valid_i  in  1  pixel valid
pix_data_i  in  DATA_WD  pixel value
sof_i  in  1  start of frame, qualified with the pixel at column 0
pix_ready_o  out  1  ready to accept a pixel
ram0_wen, ram1_wen, ram2_wen  out  1 each  bank write enables
wr_addr  out  RAM_WD  bank write address (shared)
wr_data  out  DATA_WD  bank write data (shared)
r_en_o  out  1  read request to the read controller
raddr_o  out  ADDR_WD  column to read
row_o  out  ROW_WD  current row being written
eol_o  out  1  end-of-row pulse
eof_o  out  1  end-of-frame pulse
sof_err_o  out  1  sticky: sof_i seen at a column other than 0

Behaviour:
- Reset is asynchronous and active-low on rst_ni; the clock is clk_i. Reset clears the state to IDLE and sets wcol=0, wbank=0, waddr=0, and row=0. All registered outputs reset to 0. pix_ready_o=1 after reset.
- Accept: pix_valid_i && pix_ready_o. pix_ready_o is combinational: 1 in IDLE and ROW, 0 in FLUSH.
- FSM:
  - IDLE (wcol=0): on accept -> ROW.
  - ROW: on accept of wcol=IMG_W-1 -> FLUSH.
  - FLUSH: lasts exactly one cycle, then -> IDLE.
- Counters:
  - wcol increments on each accept.
  - wbank cycles 0,1,2,0... on each accept.
  - waddr increments when wbank wraps from 2 to 0.
  - All three reset to 0 on leaving FLUSH.
  - No division or modulo logic is used.
- Write latency is 1 cycle: the cycle after an accept, ram{wbank}_wen=1 (only that bank), wr_addr=waddr, and wr_data=pix_data_i. Otherwise all wen are 0, and wr_addr/wr_data hold their last values.
- Read issue:
  - The cycle after accepting column c>=1: r_en_o=1 and raddr_o=c-1, in the same cycle as the wen for column c.
  - Accepting column 0 issues no read.
  - FLUSH cycle output (registered, visible the cycle after FLUSH is entered): r_en_o=1, raddr_o=IMG_W-1, and eol_o=1.
  - Every row emits raddr 0..IMG_W-1 exactly once, in order. r_en_o is 0 on all other cycles.
- Row/frame: row increments with eol_o.
  - When eol_o is for row IMG_H-1, eof_o=1 in the same cycle and row wraps to 0.
  - row_o is the registered row value.
- sof_i handling:
  - Accepted with wcol=0: forces row to 0 (resync).
  - Accepted with wcol!=0: sof_err_o is set to 1 (cleared only by reset); the pixel is processed normally.
  - sof_i without an accept is ignored.
- Valid gaps: no accept means no wen and no r_en; counters hold.
- pix_valid_i during FLUSH is not accepted; the source must hold the pixel.
- Reset mid-row abandons the partial row; the next accept is column 0, bank 0, address 0.

Test Plan:
1. Reset with rst_ni=0 at an arbitrary time -> all outputs 0 immediately, pix_ready_o=1; release -> IDLE.
2. One continuous 640-pixel row, data=column[7:0] -> wen bank sequence 0,1,2 repeating; wr_addr 0..213 (col 639: bank 0, addr 213); raddr_o 0..638 one cycle after the accept of col+1; FLUSH cycle has pix_ready_o=0, then raddr_o=639 with eol_o=1; row_o=1; 641 cycles total.
3. pix_valid_i toggling every other cycle for a full row -> wen/r_en only after accepts, raddr sequence unbroken 0..639, wr_addr/bank identical to scenario 2.
4. Full frame of 480 rows -> 480 eol_o pulses; eof_o coincident with the 480th eol_o only; row_o returns to 0.
5. sof_i=1 at column 300 -> sof_err_o=1 and stays set; column 300 written to bank 0, address 100; read sequence unaffected.
6. Reset asserted at column 300, then a new row -> first write bank 0, address 0; first r_en_o raddr_o=0 after column 1 is accepted.

Source files
------------

// File: rtl/write_buffer_ctrl.sv
// Write-side controller for the Sobel banked line buffers: distributes each
// raster pixel across three RAM banks and issues lagged in-order column reads.
module write_buffer_ctrl #(
    parameter int DATA_WD = 8,
    parameter int ADDR_WD = 10,
    parameter int RAM_WD  = 8,
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int ROW_WD  = 9
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pix_valid_i,
    input  logic [DATA_WD-1:0] pix_data_i,
    input  logic               sof_i,
    output logic               pix_ready_o,
    output logic               ram0_wen,
    output logic               ram1_wen,
    output logic               ram2_wen,
    output logic [RAM_WD-1:0]  wr_addr,
    output logic [DATA_WD-1:0] wr_data,
    output logic               r_en_o,
    output logic [ADDR_WD-1:0] raddr_o,
    output logic [ROW_WD-1:0]  row_o,
    output logic               eol_o,
    output logic               eof_o,
    output logic               sof_err_o
);

    typedef enum logic [1:0] {IDLE, ROW, FLUSH} state_t;

    localparam logic [ADDR_WD-1:0] LAST_COL = ADDR_WD'(IMG_W - 1);
    localparam logic [ROW_WD-1:0]  LAST_ROW = ROW_WD'(IMG_H - 1);

    state_t              state_reg;
    logic [ADDR_WD-1:0]  wcol_reg;
    logic [1:0]          wbank_reg;
    logic [RAM_WD-1:0]   waddr_reg;
    logic [ROW_WD-1:0]   row_reg;
    logic [2:0]          wen_reg;
    logic [2:0]          bank_sel;
    logic                accept;

    assign pix_ready_o = (state_reg != FLUSH);
    assign accept      = pix_valid_i && pix_ready_o;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bank_sel
            assign bank_sel[gi] = (wbank_reg == 2'(gi));
        end
    endgenerate

    assign ram0_wen = wen_reg[0];
    assign ram1_wen = wen_reg[1];
    assign ram2_wen = wen_reg[2];
    assign row_o    = row_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            wcol_reg  <= '0;
            wbank_reg <= '0;
            waddr_reg <= '0;
            row_reg   <= '0;
            wen_reg   <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            r_en_o    <= 1'b0;
            raddr_o   <= '0;
            eol_o     <= 1'b0;
            eof_o     <= 1'b0;
            sof_err_o <= 1'b0;
        end else begin
            wen_reg <= '0;
            r_en_o  <= 1'b0;
            eol_o   <= 1'b0;
            eof_o   <= 1'b0;
            case (state_reg)
                IDLE, ROW: begin
                    if (accept) begin
                        wen_reg  <= bank_sel;
                        wr_addr  <= waddr_reg;
                        wr_data  <= pix_data_i;
                        // Column c is read only once column c+1 has been written.
                        if (wcol_reg != '0) begin
                            r_en_o  <= 1'b1;
                            raddr_o <= wcol_reg - ADDR_WD'(1);
                        end
                        wcol_reg <= wcol_reg + ADDR_WD'(1);
                        if (wbank_reg == 2'd2) begin
                            wbank_reg <= 2'd0;
                            waddr_reg <= waddr_reg + RAM_WD'(1);
                        end else begin
                            wbank_reg <= wbank_reg + 2'd1;
                        end
                        if (sof_i) begin
                            if (wcol_reg == '0) row_reg   <= '0;
                            else                sof_err_o <= 1'b1;
                        end
                        state_reg <= (wcol_reg == LAST_COL) ? FLUSH : ROW;
                    end
                end
                FLUSH: begin
                    // Final column read of the row; no pixel accepted this cycle.
                    r_en_o    <= 1'b1;
                    raddr_o   <= LAST_COL;
                    eol_o     <= 1'b1;
                    wcol_reg  <= '0;
                    wbank_reg <= '0;
                    waddr_reg <= '0;
                    if (row_reg == LAST_ROW) begin
                        row_reg <= '0;
                        eof_o   <= 1'b1;
                    end else begin
                        row_reg <= row_reg + ROW_WD'(1);
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer_ctrl.sv
// Self-checking bench for write_buffer_ctrl: randomized valid gaps checked
// cycle by cycle against a column/row arithmetic reference model.
module tb_write_buffer_ctrl;

    localparam int DATA_WD = 8;
    localparam int ADDR_WD = 10;
    localparam int RAM_WD  = 8;
    localparam int IMG_W   = 10;
    localparam int IMG_H   = 4;
    localparam int ROW_WD  = 9;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               pix_valid_i;
    logic [DATA_WD-1:0] pix_data_i;
    logic               sof_i;
    logic               pix_ready_o;
    logic               ram0_wen, ram1_wen, ram2_wen;
    logic [RAM_WD-1:0]  wr_addr;
    logic [DATA_WD-1:0] wr_data;
    logic               r_en_o;
    logic [ADDR_WD-1:0] raddr_o;
    logic [ROW_WD-1:0]  row_o;
    logic               eol_o, eof_o, sof_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: column about to be written, row, flush pending, error flag.
    int m_col = 0;
    int m_row = 0;
    bit m_flush = 0;
    bit m_err = 0;
    int eol_seen = 0;
    int eof_seen = 0;

    write_buffer_ctrl #(
        .DATA_WD(DATA_WD), .ADDR_WD(ADDR_WD), .RAM_WD(RAM_WD),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ROW_WD(ROW_WD)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .pix_valid_i(pix_valid_i), .pix_data_i(pix_data_i), .sof_i(sof_i),
        .pix_ready_o(pix_ready_o),
        .ram0_wen(ram0_wen), .ram1_wen(ram1_wen), .ram2_wen(ram2_wen),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .r_en_o(r_en_o), .raddr_o(raddr_o), .row_o(row_o),
        .eol_o(eol_o), .eof_o(eof_o), .sof_err_o(sof_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check ready now, drive inputs, advance the model, check registered outputs.
    task automatic cycle(input bit v, input logic [DATA_WD-1:0] d, input bit s, output bit acc);
        bit exp_ready, exp_ren, exp_eol, exp_eof;
        logic [2:0] exp_wen;
        int exp_waddr, exp_raddr;
        exp_ready = !m_flush;
        chk("pix_ready", 32'(pix_ready_o), 32'(exp_ready));
        pix_valid_i = v;
        pix_data_i  = d;
        sof_i       = s;
        acc       = v && exp_ready;
        exp_wen   = acc ? (3'b001 << (m_col % 3)) : 3'b000;
        exp_waddr = m_col / 3;
        exp_ren   = acc ? (m_col != 0) : m_flush;
        exp_raddr = acc ? m_col - 1 : IMG_W - 1;
        exp_eol   = m_flush;
        exp_eof   = m_flush && (m_row == IMG_H - 1);
        if (m_flush) begin
            m_row   = (m_row + 1) % IMG_H;
            m_col   = 0;
            m_flush = 0;
        end else if (acc) begin
            if (s && m_col == 0) m_row = 0;
            if (s && m_col != 0) m_err = 1;
            m_flush = (m_col == IMG_W - 1);
            m_col   = m_col + 1;
        end
        @(posedge clk_i);
        #1;
        chk("wen", 32'({ram2_wen, ram1_wen, ram0_wen}), 32'(exp_wen));
        if (acc) begin
            chk("wr_addr", 32'(wr_addr), 32'(exp_waddr));
            chk("wr_data", 32'(wr_data), 32'(d));
        end
        chk("r_en", 32'(r_en_o), 32'(exp_ren));
        if (exp_ren) chk("raddr", 32'(raddr_o), 32'(exp_raddr));
        chk("eol", 32'(eol_o), 32'(exp_eol));
        chk("eof", 32'(eof_o), 32'(exp_eof));
        chk("row", 32'(row_o), 32'(m_row));
        chk("sof_err", 32'(sof_err_o), 32'(m_err));
        if (eol_o) eol_seen++;
        if (eof_o) eof_seen++;
    endtask

    // Offer one pixel until it is accepted; gap_pct controls idle cycles before it.
    task automatic send(input logic [DATA_WD-1:0] d, input bit s, input int gap_pct);
        bit acc;
        int guard;
        guard = 0;
        acc = 0;
        while (!acc && guard < 50) begin
            if ($urandom_range(99) < gap_pct) cycle(1'b0, DATA_WD'($urandom), 1'b0, acc);
            else                              cycle(1'b1, d, s, acc);
            guard++;
        end
        if (!acc) chk("accept_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, DATA_WD'($urandom), 1'b0, acc);
    endtask

    task automatic reset_check();
        chk("rst_wen", 32'({ram2_wen, ram1_wen, ram0_wen}), 32'(0));
        chk("rst_waddr", 32'(wr_addr), 32'(0));
        chk("rst_wdata", 32'(wr_data), 32'(0));
        chk("rst_ren", 32'(r_en_o), 32'(0));
        chk("rst_raddr", 32'(raddr_o), 32'(0));
        chk("rst_row", 32'(row_o), 32'(0));
        chk("rst_eol", 32'({eof_o, eol_o}), 32'(0));
        chk("rst_err", 32'(sof_err_o), 32'(0));
        chk("rst_ready", 32'(pix_ready_o), 32'(1));
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge.
    task automatic async_reset();
        #2 rst_ni = 1'b0;
        #1 reset_check();
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        m_col = 0; m_row = 0; m_flush = 0; m_err = 0;
    endtask

    initial begin
        bit acc;
        int eol_base, eof_base;
        rst_ni = 1'b0; pix_valid_i = 1'b0; pix_data_i = '0; sof_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 reset_check();
        rst_ni = 1'b1;

        // Continuous row, data = column index.
        for (int c = 0; c < IMG_W; c++) send(DATA_WD'(c), c == 0, 0);
        idle(3);

        // Valid toggling every other cycle.
        for (int c = 0; c < IMG_W; c++) begin
            cycle(1'b0, DATA_WD'($urandom), 1'b0, acc);
            send(DATA_WD'(c), 1'b0, 0);
        end
        idle(3);

        // Full frame with random gaps; sof at column 0 resyncs row to 0.
        eol_base = eol_seen; eof_base = eof_seen;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                send(DATA_WD'($urandom), (r == 0 && c == 0), 30);
        idle(3);
        chk("frame_eols", 32'(eol_seen - eol_base), 32'(IMG_H));
        chk("frame_eofs", 32'(eof_seen - eof_base), 32'(1));
        chk("frame_row", 32'(row_o), 32'(0));

        // Misplaced sof sets the sticky error.
        for (int c = 0; c < IMG_W; c++) send(DATA_WD'($urandom), c == 6, 20);
        idle(3);
        for (int c = 0; c < IMG_W; c++) send(DATA_WD'($urandom), 1'b0, 20);
        idle(2);
        chk("sof_err_sticky", 32'(sof_err_o), 32'(1));

        // Reset partway through a row, then a fresh row starts at bank 0 address 0.
        for (int c = 0; c < 5; c++) send(DATA_WD'($urandom), 1'b0, 0);
        async_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IMG_W; c++)
                send(DATA_WD'($urandom), $urandom_range(9) == 0, 40);
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
